// File: rtl/ctrl_ramp_pkg.sv
// Shared loop-control definitions: ramp FSM encoding and default datapath widths.
package ctrl_ramp_pkg;

   localparam int W_DEF  = 16;
   localparam int WD_DEF = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RAMP = 1'b1
   } ramp_state_t;

endpackage

// File: rtl/ctrl_ramp_tick_gen.sv
// Free-running prescaler: a tick every div+1 cycles, count frozen while en is low.
module tick_gen
   import ctrl_ramp_pkg::*;
#(
   parameter int wd = WD_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [wd-1:0] div,
   input  logic          en,
   output logic          tick
);

   localparam logic [wd-1:0] ONE = 1;

   logic [wd-1:0] count;

   assign tick = en && (count == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         count <= (count == '0) ? div : count - ONE;
      end
   end

endmodule

// File: rtl/ctrl_ramp.sv
// Slew-rate limiter for the PI loop control word: clamps a strobed setpoint
// and walks ctrlout toward it by at most step per prescaler tick.
module ctrl_ramp
   import ctrl_ramp_pkg::*;
#(
   parameter int w  = W_DEF,
   parameter int wd = WD_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic signed [w-1:0] target,
   input  logic                strobe_in,
   input  logic        [w-1:0] step,
   input  logic signed [w-1:0] hi_lim,
   input  logic signed [w-1:0] lo_lim,
   input  logic       [wd-1:0] tick_div,
   input  logic                hold,
   output logic signed [w-1:0] ctrlout,
   output logic                strobe_out,
   output logic                busy,
   output logic                clipped
);

   ramp_state_t         state;
   logic signed [w-1:0] tgt_r;
   logic signed [w-1:0] tgt_hi;
   logic signed [w-1:0] tgt_c;
   logic signed [w:0]   diff;
   logic        [w:0]   mag;
   logic        [w:0]   step_ext;
   logic signed [w-1:0] moved;
   logic signed [w-1:0] ctrl_nxt;
   logic                tick;
   logic                near;
   logic                upd;

   tick_gen #(.wd(wd)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .div  (tick_div),
      .en   (!hold),
      .tick (tick)
   );

   // Upper bound applied first, lower bound last, so lo_lim wins when the limits cross.
   always_comb begin
      tgt_hi = (target > hi_lim) ? hi_lim : target;
      tgt_c  = (tgt_hi < lo_lim) ? lo_lim : tgt_hi;
   end

   // moved is only used when |diff| > step, so it lies strictly between ctrlout
   // and tgt_r and the w-bit result is exact.
   always_comb begin
      diff     = {tgt_r[w-1], tgt_r} - {ctrlout[w-1], ctrlout};
      mag      = diff[w] ? -diff : diff;
      step_ext = {1'b0, step};
      near     = (step == '0) || (mag <= step_ext);
      moved    = diff[w] ? (ctrlout - $signed(step)) : (ctrlout + $signed(step));
      upd      = (state == RAMP) && !hold && ((step == '0) || tick);
      ctrl_nxt = ctrlout;
      if (upd) begin
         ctrl_nxt = near ? tgt_r : moved;
      end
   end

   assign busy = (state == RAMP);

   // A capture compares against the post-update value so a retarget that lands
   // exactly where this cycle's step ends leaves nothing left to ramp.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ctrlout    <= '0;
         tgt_r      <= '0;
         strobe_out <= 1'b0;
         clipped    <= 1'b0;
      end else begin
         ctrlout    <= ctrl_nxt;
         strobe_out <= (ctrl_nxt != ctrlout);
         if (strobe_in) begin
            tgt_r   <= tgt_c;
            clipped <= (tgt_c != target);
            state   <= (tgt_c != ctrl_nxt) ? RAMP : IDLE;
         end else if (upd && (ctrl_nxt == tgt_r)) begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_ctrl_ramp.sv
// Directed self-checking bench for ctrl_ramp; inputs change and outputs are sampled on negedge.
module tb_ctrl_ramp;

   localparam int W  = 16;
   localparam int WD = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic signed [W-1:0] target;
   logic                strobe_in;
   logic        [W-1:0] step;
   logic signed [W-1:0] hi_lim;
   logic signed [W-1:0] lo_lim;
   logic       [WD-1:0] tick_div;
   logic                hold;
   logic signed [W-1:0] ctrlout;
   logic                strobe_out;
   logic                busy;
   logic                clipped;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   ctrl_ramp #(.w(W), .wd(WD)) dut (
      .clk        (clk),
      .rst        (rst),
      .target     (target),
      .strobe_in  (strobe_in),
      .step       (step),
      .hi_lim     (hi_lim),
      .lo_lim     (lo_lim),
      .tick_div   (tick_div),
      .hold       (hold),
      .ctrlout    (ctrlout),
      .strobe_out (strobe_out),
      .busy       (busy),
      .clipped    (clipped)
   );

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      strobe_in = 1'b0;
      hold      = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send(input logic signed [W-1:0] t);
      target    = t;
      strobe_in = 1'b1;
      @(negedge clk);
      strobe_in = 1'b0;
   endtask

   task automatic test_reset();
      target = 16'sd0; strobe_in = 1'b0; step = 16'd0; hold = 1'b0;
      hi_lim = 16'sd100; lo_lim = -16'sd100; tick_div = 8'd0;
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (ctrlout !== 16'sd0 || busy !== 1'b0 || strobe_out !== 1'b0 || clipped !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset: ctrlout=%0d busy=%b strobe_out=%b clipped=%b, expected 0 0 0 0",
                  ctrlout, busy, strobe_out, clipped);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic_ramp();
      int pulses = 0;
      step = 16'd100; tick_div = 8'd0; hi_lim = 16'sd30000; lo_lim = -16'sd30000;
      do_reset();
      send(16'sd1000);
      tests_run++;
      if (busy !== 1'b1 || ctrlout !== 16'sd0) begin
         tests_failed++;
         $display("[TB] FAIL basic_start: busy=%b ctrlout=%0d, expected 1 0", busy, ctrlout);
      end
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (strobe_out === 1'b1) pulses++;
         tests_run++;
         if (ctrlout !== 16'(100 * k) || busy !== (k < 10)) begin
            tests_failed++;
            $display("[TB] FAIL basic_step k=%0d: ctrlout=%0d busy=%b, expected %0d %b",
                     k, ctrlout, busy, 100 * k, (k < 10));
         end
      end
      @(negedge clk);
      if (strobe_out === 1'b1) pulses++;
      tests_run++;
      if (pulses != 10 || ctrlout !== 16'sd1000 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL basic_end: pulses=%0d ctrlout=%0d busy=%b, expected 10 1000 0",
                  pulses, ctrlout, busy);
      end
   endtask

   task automatic test_step_zero();
      step = 16'd0;
      send(-16'sd5000);
      tests_run++;
      if (busy !== 1'b1 || ctrlout !== 16'sd1000 || strobe_out !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL step0_n1: busy=%b ctrlout=%0d strobe_out=%b, expected 1 1000 0",
                  busy, ctrlout, strobe_out);
      end
      @(negedge clk);
      tests_run++;
      if (ctrlout !== -16'sd5000 || strobe_out !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL step0_n2: ctrlout=%0d strobe_out=%b busy=%b, expected -5000 1 0",
                  ctrlout, strobe_out, busy);
      end
      @(negedge clk);
      tests_run++;
      if (ctrlout !== -16'sd5000 || strobe_out !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL step0_n3: ctrlout=%0d strobe_out=%b, expected -5000 0", ctrlout, strobe_out);
      end
   endtask

   task automatic test_clip();
      step = 16'd500; tick_div = 8'd3; hi_lim = 16'sd2000; lo_lim = -16'sd30000;
      do_reset();
      send(16'sd9000);
      tests_run++;
      if (clipped !== 1'b1 || busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL clip_capture: clipped=%b busy=%b, expected 1 1", clipped, busy);
      end
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         tests_run++;
         if (ctrlout !== 16'(500 * (c / 4)) || strobe_out !== (c % 4 == 0)) begin
            tests_failed++;
            $display("[TB] FAIL clip_step c=%0d: ctrlout=%0d strobe_out=%b, expected %0d %b",
                     c, ctrlout, strobe_out, 500 * (c / 4), (c % 4 == 0));
         end
      end
      repeat (4) @(negedge clk);
      tests_run++;
      if (ctrlout !== 16'sd2000 || busy !== 1'b0 || strobe_out !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL clip_end: ctrlout=%0d busy=%b strobe_out=%b, expected 2000 0 0",
                  ctrlout, busy, strobe_out);
      end
   endtask

   task automatic test_lo_wins();
      step = 16'd0; tick_div = 8'd0; lo_lim = 16'sd500; hi_lim = 16'sd200;
      do_reset();
      send(16'sd0);
      tests_run++;
      if (clipped !== 1'b1 || busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL lo_wins_capture: clipped=%b busy=%b, expected 1 1", clipped, busy);
      end
      @(negedge clk);
      tests_run++;
      if (ctrlout !== 16'sd500 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL lo_wins_value: ctrlout=%0d busy=%b, expected 500 0", ctrlout, busy);
      end
      send(16'sd500);
      tests_run++;
      if (clipped !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL same_target: clipped=%b busy=%b, expected 0 0", clipped, busy);
      end
      @(negedge clk);
      tests_run++;
      if (ctrlout !== 16'sd500 || strobe_out !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL same_target_out: ctrlout=%0d strobe_out=%b, expected 500 0",
                  ctrlout, strobe_out);
      end
   endtask

   task automatic test_reverse();
      int exp_seq[8] = '{400, 300, 200, 100, 0, -100, -200, -250};
      step = 16'd100; tick_div = 8'd0; hi_lim = 16'sd30000; lo_lim = -16'sd30000;
      do_reset();
      send(16'sd1000);
      repeat (4) @(negedge clk);
      tests_run++;
      if (ctrlout !== 16'sd400) begin
         tests_failed++;
         $display("[TB] FAIL reverse_pre: ctrlout=%0d, expected 400", ctrlout);
      end
      // The retarget edge is also a tick, so it still steps toward the old target.
      send(-16'sd250);
      tests_run++;
      if (ctrlout !== 16'sd500 || busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reverse_coincide: ctrlout=%0d busy=%b, expected 500 1", ctrlout, busy);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         tests_run++;
         if (ctrlout !== 16'(exp_seq[i]) || strobe_out !== 1'b1 || busy !== (i < 7)) begin
            tests_failed++;
            $display("[TB] FAIL reverse_step i=%0d: ctrlout=%0d strobe_out=%b busy=%b, expected %0d 1 %b",
                     i, ctrlout, strobe_out, busy, exp_seq[i], (i < 7));
         end
      end
   endtask

   task automatic test_hold();
      step = 16'd100; tick_div = 8'd3; hi_lim = 16'sd30000; lo_lim = -16'sd30000;
      do_reset();
      send(16'sd1000);
      repeat (4) @(negedge clk);
      tests_run++;
      if (ctrlout !== 16'sd100 || strobe_out !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL hold_pre: ctrlout=%0d strobe_out=%b, expected 100 1", ctrlout, strobe_out);
      end
      @(negedge clk);
      hold = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         tests_run++;
         if (ctrlout !== 16'sd100 || strobe_out !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL hold_frozen i=%0d: ctrlout=%0d strobe_out=%b busy=%b, expected 100 0 1",
                     i, ctrlout, strobe_out, busy);
         end
      end
      hold = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (ctrlout !== 16'sd100 || strobe_out !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL hold_phase_early: ctrlout=%0d strobe_out=%b, expected 100 0", ctrlout, strobe_out);
      end
      @(negedge clk);
      tests_run++;
      if (ctrlout !== 16'sd200 || strobe_out !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL hold_resume: ctrlout=%0d strobe_out=%b, expected 200 1", ctrlout, strobe_out);
      end
   endtask

   task automatic test_extremes();
      step = 16'd0; tick_div = 8'd0; hi_lim = 16'sd32767; lo_lim = -16'sd32768;
      do_reset();
      send(-16'sd32768);
      @(negedge clk);
      tests_run++;
      if (ctrlout !== -16'sd32768) begin
         tests_failed++;
         $display("[TB] FAIL extreme_low: ctrlout=%0d, expected -32768", ctrlout);
      end
      step = 16'hFFFF;
      send(16'sd32767);
      tests_run++;
      if (busy !== 1'b1 || ctrlout !== -16'sd32768) begin
         tests_failed++;
         $display("[TB] FAIL extreme_capture: busy=%b ctrlout=%0d, expected 1 -32768", busy, ctrlout);
      end
      @(negedge clk);
      tests_run++;
      if (ctrlout !== 16'sd32767 || strobe_out !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL extreme_jump: ctrlout=%0d strobe_out=%b busy=%b, expected 32767 1 0",
                  ctrlout, strobe_out, busy);
      end
   endtask

   task automatic test_async_reset();
      step = 16'd1;
      send(-16'sd32768);
      repeat (3) @(negedge clk);
      tests_run++;
      if (ctrlout !== 16'sd32764 || busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL slow_ramp: ctrlout=%0d busy=%b, expected 32764 1", ctrlout, busy);
      end
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if (ctrlout !== 16'sd0 || busy !== 1'b0 || strobe_out !== 1'b0 || clipped !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL async_reset: ctrlout=%0d busy=%b strobe_out=%b clipped=%b, expected 0 0 0 0",
                  ctrlout, busy, strobe_out, clipped);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      tests_run++;
      if (ctrlout !== 16'sd0 || busy !== 1'b0 || strobe_out !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL post_reset_idle: ctrlout=%0d busy=%b strobe_out=%b, expected 0 0 0",
                  ctrlout, busy, strobe_out);
      end
   endtask

   initial begin
      test_reset();
      test_basic_ramp();
      test_step_zero();
      test_clip();
      test_lo_wins();
      test_reverse();
      test_hold();
      test_extremes();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
